// File: rtl/tl_ul_pkg.sv
// Shared TL-UL encodings, FSM state type and the size/address lane-mask helper
// used by the TL-UL initiator.
package tl_ul_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int MASK_W = 4;
  localparam int SIZE_W = 4;

  typedef enum logic [2:0] {
    A_PUTFULL    = 3'd0,
    A_PUTPARTIAL = 3'd1,
    A_GET        = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESSACK     = 3'd0,
    D_ACCESSACKDATA = 3'd1,
    D_HINTACK       = 3'd2
  } d_opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2
  } state_e;

  // Sub-word accesses select lanes from the low address bits; word and larger use all lanes.
  function automatic logic [MASK_W-1:0] lane_mask(input logic [SIZE_W-1:0] size,
                                                  input logic [1:0]        addr_lo);
    logic [MASK_W-1:0] m;
    m = 4'hF;
    if (size == 4'd0) begin
      m = 4'b0001 << addr_lo;
    end else if (size == 4'd1) begin
      m = addr_lo[1] ? 4'hC : 4'h3;
    end
    return m;
  endfunction

endpackage

// File: rtl/tilelink_ul_master.sv
// TL-UL initiator: one outstanding Get/PutFull/PutPartial at a time, multi-beat Get,
// D-beat protocol checks and a response-wait watchdog.
module tilelink_ul_master
  import tl_ul_pkg::*;
#(
  parameter int SOURCE_ID = 0,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_partial,
  input  logic [31:0] cmd_address,
  input  logic [3:0]  cmd_size,
  input  logic [3:0]  cmd_mask,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        rsp_error,
  input  logic        a_ready,
  output logic        a_valid,
  output logic [2:0]  a_bits_opcode,
  output logic [2:0]  a_bits_param,
  output logic [3:0]  a_bits_size,
  output logic        a_bits_source,
  output logic [31:0] a_bits_address,
  output logic [3:0]  a_bits_mask,
  output logic [31:0] a_bits_data,
  output logic        d_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_bits_opcode,
  input  logic [1:0]  d_bits_param,
  input  logic [3:0]  d_bits_size,
  input  logic        d_bits_source,
  input  logic        d_bits_sink,
  input  logic [31:0] d_bits_data,
  input  logic        d_bits_error,
  output logic        err_protocol,
  output logic        err_timeout,
  output logic        busy
);

  state_e            state_q;
  logic              a_valid_q;
  logic [2:0]        a_opcode_q;
  logic [3:0]        a_size_q;
  logic [31:0]       a_addr_q;
  logic [3:0]        a_mask_q;
  logic [31:0]       a_data_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [CNT_W-1:0]  byte_cnt_d;
  logic [CNT_W-1:0]  timer_q;
  logic              err_protocol_q;
  logic              err_timeout_q;

  logic              in_dwait;
  logic              is_get;
  logic              beat_fire;
  logic              beat_last;
  logic              beat_bad;
  logic              stray_d;
  logic              illegal_put;
  logic              timer_hit;
  logic [2:0]        exp_d_opcode;
  logic              unused_sink;

  assign unused_sink  = d_bits_sink;
  assign in_dwait     = (state_q == D_WAIT);
  assign is_get       = (a_opcode_q == 3'(A_GET));
  assign beat_fire    = in_dwait && d_valid && rsp_ready;
  assign byte_cnt_d   = byte_cnt_q + CNT_W'(4);
  // Puts are single-beat; a Get ends once the bytes delivered cover 2^size.
  assign beat_last    = !is_get || (byte_cnt_d >= (CNT_W'(1) << a_size_q));
  assign exp_d_opcode = is_get ? 3'(D_ACCESSACKDATA) : 3'(D_ACCESSACK);
  assign beat_bad     = (d_bits_opcode != exp_d_opcode) || (d_bits_source != 1'(SOURCE_ID)) ||
                        (d_bits_size != a_size_q) || (d_bits_param != 2'd0);
  assign stray_d      = d_valid && !in_dwait;
  assign illegal_put  = (state_q == IDLE) && cmd_valid && cmd_write && (cmd_size > 4'd2);
  assign timer_hit    = (TIMEOUT != 0) && (timer_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      a_valid_q      <= 1'b0;
      a_opcode_q     <= 3'd0;
      a_size_q       <= 4'd0;
      a_addr_q       <= 32'd0;
      a_mask_q       <= 4'd0;
      a_data_q       <= 32'd0;
      byte_cnt_q     <= '0;
      timer_q        <= '0;
      err_protocol_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      if (stray_d || illegal_put || (beat_fire && beat_bad)) err_protocol_q <= 1'b1;
      if (in_dwait && timer_hit) err_timeout_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (cmd_valid && !illegal_put) begin
            state_q    <= A_SEND;
            a_valid_q  <= 1'b1;
            a_opcode_q <= !cmd_write ? 3'(A_GET) :
                          (cmd_partial ? 3'(A_PUTPARTIAL) : 3'(A_PUTFULL));
            a_size_q   <= cmd_size;
            a_addr_q   <= cmd_address;
            a_mask_q   <= (cmd_write && cmd_partial) ? cmd_mask
                                                     : lane_mask(cmd_size, cmd_address[1:0]);
            a_data_q   <= cmd_write ? cmd_wdata : 32'd0;
          end
        end
        A_SEND: begin
          if (a_ready) begin
            a_valid_q  <= 1'b0;
            state_q    <= D_WAIT;
            byte_cnt_q <= '0;
            timer_q    <= '0;
          end
        end
        D_WAIT: begin
          if (beat_fire) begin
            timer_q <= '0;
            if (beat_last) state_q <= IDLE;
            else           byte_cnt_q <= byte_cnt_d;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign a_valid        = a_valid_q;
  assign a_bits_opcode  = a_opcode_q;
  assign a_bits_param   = 3'd0;
  assign a_bits_size    = a_size_q;
  assign a_bits_source  = 1'(SOURCE_ID);
  assign a_bits_address = a_addr_q;
  assign a_bits_mask    = a_mask_q;
  assign a_bits_data    = a_data_q;
  assign d_ready        = in_dwait && rsp_ready;
  assign rsp_valid      = in_dwait && d_valid;
  assign rsp_rdata      = d_bits_data;
  assign rsp_error      = d_bits_error;
  assign rsp_last       = in_dwait && beat_last;
  assign err_protocol   = err_protocol_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_tilelink_ul_master.sv
// Directed bench for tilelink_ul_master: stimulus pushes expected response beats into
// a scoreboard queue that an independent monitor drains on each rsp handshake.
module tb_tilelink_ul_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_partial;
  logic [31:0] cmd_address, cmd_wdata;
  logic [3:0]  cmd_size, cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_error;
  logic [31:0] rsp_rdata;
  logic        a_ready, a_valid, a_bits_source;
  logic [2:0]  a_bits_opcode, a_bits_param;
  logic [3:0]  a_bits_size, a_bits_mask;
  logic [31:0] a_bits_address, a_bits_data;
  logic        d_ready, d_valid, d_bits_source, d_bits_sink, d_bits_error;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [3:0]  d_bits_size;
  logic [31:0] d_bits_data;
  logic        err_protocol, err_timeout, busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];

  tilelink_ul_master #(.SOURCE_ID(0), .TIMEOUT(8), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_partial(cmd_partial), .cmd_address(cmd_address), .cmd_size(cmd_size),
    .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .rsp_error(rsp_error),
    .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode),
    .a_bits_param(a_bits_param), .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
    .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data),
    .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode),
    .d_bits_param(d_bits_param), .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
    .d_bits_sink(d_bits_sink), .d_bits_data(d_bits_data), .d_bits_error(d_bits_error),
    .err_protocol(err_protocol), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every beat the DUT hands over must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rsp_unexpected: got beat %h with no expected beat queued", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_last", rsp_last, e.last);
        chk("rsp_error", rsp_error, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic part, input logic [31:0] addr,
                       input logic [3:0] size, input logic [3:0] mask, input logic [31:0] wd);
    cmd_valid = 1'b1; cmd_write = wr; cmd_partial = part;
    cmd_address = addr; cmd_size = size; cmd_mask = mask; cmd_wdata = wd;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic a_accept(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wd, input bit chk_wd,
                          input int stall);
    for (int i = 0; i <= stall; i++) begin
      chk("a_valid", a_valid, 1'b1);
      chk("a_fields", {a_bits_opcode, a_bits_size, a_bits_address, a_bits_mask, a_bits_param,
                       a_bits_source}, {op, size, addr, mask, 3'd0, 1'b0});
      if (chk_wd) chk("a_data", a_bits_data, wd);
      if (i < stall) tick();
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("a_valid_after_hs", a_valid, 1'b0);
  endtask

  // Drive n D beats (indices first..first+n-1 of total); expect last on index total-1.
  task automatic d_beats(input int first, input int n, input int total, input logic [31:0] base,
                         input logic [2:0] op, input logic src, input logic [3:0] sz,
                         input logic err, input bit toggle, input bit chk_data);
    for (int i = first; i < first + n; i++) begin
      exp_t e;
      bit hs, hs_now;
      e.data = base + 32'(i); e.last = (i == total - 1); e.err = err; e.chk_data = chk_data;
      sb.push_back(e);
      d_valid = 1'b1; d_bits_opcode = op; d_bits_source = src; d_bits_size = sz;
      d_bits_data = base + 32'(i); d_bits_error = err;
      hs = 1'b0;
      for (int k = 0; k < 4 && !hs; k++) begin
        hs_now = rsp_ready;
        @(posedge clock);
        #1;
        if (hs_now) hs = 1'b1;
        if (toggle) rsp_ready = ~rsp_ready;
      end
      d_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_partial = 1'b0;
    cmd_address = '0; cmd_size = '0; cmd_mask = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; a_ready = 1'b0; d_valid = 1'b0; d_bits_opcode = '0;
    d_bits_param = '0; d_bits_size = '0; d_bits_source = 1'b0; d_bits_sink = 1'b0;
    d_bits_data = '0; d_bits_error = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outputs", {busy, a_valid, rsp_valid, err_protocol, err_timeout, cmd_ready, d_ready},
        7'b0000010);
    chk("rst_a_fields", {a_bits_opcode, a_bits_size, a_bits_address, a_bits_mask, a_bits_data},
        '0);
    reset_n = 1'b1;
    tick();

    // Word Get, slave answers after 3 cycles.
    issue(1'b0, 1'b0, 32'h0001_0000, 4'd2, 4'h0, 32'h0);
    a_accept(3'd4, 4'd2, 32'h0001_0000, 4'hF, 32'h0, 1'b0, 0);
    repeat (3) tick();
    d_beats(0, 1, 1, 32'hDEADBEEF, 3'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    chk("get1_idle_errs", {busy, err_protocol, err_timeout}, 3'b000);

    // 64-byte Get with rsp_ready toggling: 16 beats.
    issue(1'b0, 1'b0, 32'h0000_1000, 4'd6, 4'h0, 32'h0);
    a_accept(3'd4, 4'd6, 32'h0000_1000, 4'hF, 32'h0, 1'b0, 0);
    rsp_ready = 1'b0;
    d_beats(0, 15, 16, 32'h1000_0000, 3'd1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1);
    chk("burst_busy_mid", busy, 1'b1);
    d_beats(15, 1, 16, 32'h1000_0000, 3'd1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1);
    chk("burst_busy_after", busy, 1'b0);
    rsp_ready = 1'b1;

    // PutPartial with a_ready stalled 5 cycles.
    issue(1'b1, 1'b1, 32'h0000_0010, 4'd2, 4'h6, 32'h00AB_CD00);
    a_accept(3'd1, 4'd2, 32'h0000_0010, 4'h6, 32'h00AB_CD00, 1'b1, 5);
    d_beats(0, 1, 1, 32'h0, 3'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    chk("pput_idle", busy, 1'b0);

    // PutFull byte at lane 3; slave flags d_bits_error which is only forwarded.
    issue(1'b1, 1'b0, 32'h0000_0013, 4'd0, 4'h1, 32'h7700_0000);
    a_accept(3'd0, 4'd0, 32'h0000_0013, 4'h8, 32'h7700_0000, 1'b1, 0);
    d_beats(0, 1, 1, 32'h0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("dberr_no_proto", err_protocol, 1'b0);

    // Halfword Get in the upper half of the word.
    issue(1'b0, 1'b0, 32'h0000_0022, 4'd1, 4'h0, 32'h0);
    a_accept(3'd4, 4'd1, 32'h0000_0022, 4'hC, 32'h0, 1'b0, 0);
    d_beats(0, 1, 1, 32'h5555_AAAA, 3'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);

    // Get answered with wrong opcode and source.
    issue(1'b0, 1'b0, 32'h0000_0020, 4'd2, 4'h0, 32'h0);
    a_accept(3'd4, 4'd2, 32'h0000_0020, 4'hF, 32'h0, 1'b0, 0);
    d_beats(0, 1, 1, 32'hCAFE_F00D, 3'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    chk("bad_d_proto", err_protocol, 1'b1);
    chk("bad_d_idle", busy, 1'b0);

    // Silent slave for 20 cycles with TIMEOUT = 8.
    issue(1'b0, 1'b0, 32'h0000_0040, 4'd2, 4'h0, 32'h0);
    a_accept(3'd4, 4'd2, 32'h0000_0040, 4'hF, 32'h0, 1'b0, 0);
    repeat (6) tick();
    chk("timeout_early", err_timeout, 1'b0);
    repeat (6) tick();
    chk("timeout_set", err_timeout, 1'b1);
    repeat (8) tick();
    chk("timeout_still_busy", busy, 1'b1);
    d_beats(0, 1, 1, 32'h1234_5678, 3'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    chk("timeout_done", {busy, err_timeout, err_protocol}, 3'b011);

    // Reset asserted after 3 of 8 beats of a 32-byte Get.
    issue(1'b0, 1'b0, 32'h0000_0080, 4'd5, 4'h0, 32'h0);
    a_accept(3'd4, 4'd5, 32'h0000_0080, 4'hF, 32'h0, 1'b0, 0);
    d_beats(0, 3, 8, 32'h8000_0000, 3'd1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
    #1;
    reset_n = 1'b0;
    d_valid = 1'b1;
    #1;
    chk("async_rst_outputs", {busy, a_valid, rsp_valid, d_ready, err_protocol, err_timeout,
                              cmd_ready}, 7'b0000001);
    chk("async_rst_a_fields", {a_bits_opcode, a_bits_size, a_bits_address, a_bits_mask}, '0);
    d_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();

    // Clean 8-byte Get after reset.
    issue(1'b0, 1'b0, 32'h0000_0100, 4'd3, 4'h0, 32'h0);
    a_accept(3'd4, 4'd3, 32'h0000_0100, 4'hF, 32'h0, 1'b0, 0);
    d_beats(0, 2, 2, 32'h0BAD_0000, 3'd1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    chk("post_rst_clean", {busy, err_protocol, err_timeout}, 3'b000);

    // Put wider than a word is dropped and flagged.
    issue(1'b1, 1'b0, 32'h0000_0200, 4'd3, 4'hF, 32'h1111_2222);
    chk("illegal_put", {busy, a_valid, err_protocol}, 3'b001);

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tilelink_ul_master.md
Name: tilelink_ul_master

Overview:
- TL-UL initiator for formal/sim harnesses. Turns a simple command/response port into TileLink channel A requests (Get, PutFullData, PutPartialData) and collects channel D responses.
- Drives the same A/D bus shape used on the Rocket tile master port (32-bit data, 1-bit source). Used to exercise slave models and the tile slave port.
- One transaction outstanding at a time. Multi-beat Get is supported. Put is single-beat only.

Parameters:
- SOURCE_ID, 0, value driven on a_bits_source and expected on d_bits_source.
- TIMEOUT, 1024, cycles in D_WAIT before err_timeout is set; 0 disables the check.
- CNT_W, 16, width of the byte counter and the timeout counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = Put, 0 = Get.
- cmd_partial  in  1  Put only: 1 = PutPartialData (opcode 1), 0 = PutFullData (opcode 0).
- cmd_address  in  32  byte address.
- cmd_size  in  4  log2 of bytes; Get 0..6, Put 0..2.
- cmd_mask  in  4  byte lanes for Put.
- cmd_wdata  in  32  Put data.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response beat consumed.
- rsp_rdata  out  32  Get data beat.
- rsp_last  out  1  final beat of the transaction.
- rsp_error  out  1  d_bits_error of this beat.
- a_ready  in  1  channel A ready.
- a_valid  out  1  channel A valid.
- a_bits_opcode  out  3.
- a_bits_param  out  3.
- a_bits_size  out  4.
- a_bits_source  out  1.
- a_bits_address  out  32.
- a_bits_mask  out  4.
- a_bits_data  out  32.
- d_ready  out  1  channel D ready.
- d_valid  in  1  channel D valid.
- d_bits_opcode  in  3.
- d_bits_param  in  2.
- d_bits_size  in  4.
- d_bits_source  in  1.
- d_bits_sink  in  1.
- d_bits_data  in  32.
- d_bits_error  in  1.
- err_protocol  out  1  sticky: a D beat failed the checks below.
- err_timeout  out  1  sticky: D_WAIT exceeded TIMEOUT.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE, all A fields = 0, a_valid = 0, rsp_valid = 0, err_* = 0, counters = 0.
- States: IDLE, A_SEND, D_WAIT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register the command and go to A_SEND; the A request appears on the next cycle (1-cycle latency).
  - Opcode encoding: Get = 4; PutFullData = 0; PutPartialData = 1.
  - Put with cmd_size > 2 is illegal: set err_protocol, drop the command, stay in IDLE.
- A_SEND:
  - a_valid = 1. Fields are held stable until a_ready; a_valid never drops before the handshake.
  - Field values: param = 0, source = SOURCE_ID.
  - Mask: Get = all lanes valid for sizes >= 2; for size 0/1, lanes are selected by address[1:0]. PutFull = lanes derived the same way as Get; PutPartial = cmd_mask.
  - On a_valid && a_ready: byte_cnt = 0, timer = 0, go to D_WAIT.
- D_WAIT:
  - d_ready = rsp_ready. rsp_valid = d_valid (combinational pass-through).
  - rsp_rdata = d_bits_data; rsp_error = d_bits_error.
  - Per accepted beat: next = byte_cnt + 4 (CNT_W bits, no wrap for size <= 6). rsp_last = (next >= 1 << size_reg). A Put is always last.
  - On the beat with rsp_last: go to IDLE. Otherwise byte_cnt = next.
  - Checks per beat. Any failure sets err_protocol; the beat is still forwarded and state advances normally.
    - d_bits_opcode: 1 (AccessAckData) for Get, 0 (AccessAck) for Put.
    - d_bits_source == SOURCE_ID.
    - d_bits_size == size_reg.
    - d_bits_param == 0.
  - Timer counts cycles with no accepted beat and clears on each beat.
    - When timer == TIMEOUT and TIMEOUT != 0: set err_timeout and keep waiting; a late response is still accepted.
    - The timer saturates.
- d_valid outside D_WAIT: d_ready = 0 and err_protocol is set.
- Same-cycle events: the last D beat and a new cmd_valid are not overlapped. cmd_ready is high only in IDLE, so throughput is at most one command per 3 cycles.
- Reset mid-transaction: abort immediately to IDLE. Responses in flight are not tracked; the harness resets the slave too.
- err_* clear only on reset.

Decomposition:
- Package tl_ul_pkg:
  - A opcodes GET/PUTFULL/PUTPARTIAL, D opcodes ACCESSACK/ACCESSACKDATA/HINTACK.
  - Field widths.
  - State enum.
  - Function for the size/address-to-mask derivation.
- No sub-module; optionally tl_ul_d_checker for the D-beat checks.

Test Plan:
- Get 0x0001_0000 size 2, slave acks after 3 cycles with data 0xDEADBEEF -> a_opcode 4, mask 0xF; one rsp beat 0xDEADBEEF, rsp_last = 1; errors stay 0.
- Get size 6, rsp_ready toggling every cycle -> 16 beats accepted, rsp_last only on beat 16, busy falls the following cycle.
- PutPartial address 0x10, mask 0x6, data 0x00AB_CD00, a_ready held low 5 cycles -> a_valid and all fields stable throughout; AccessAck completes; no rdata checked.
- Get with slave replying opcode 0 and source 1 -> beat forwarded; err_protocol = 1 and sticky.
- TIMEOUT = 8, slave silent 20 cycles then acks -> err_timeout rises at cycle 8; the ack is accepted and the FSM returns to IDLE.
- reset_n pulsed low mid-Get (after 3 of 8 beats) -> all outputs at reset values asynchronously; next command starts cleanly.
